key_schedule_ctrl: RTL

Sequential AES-128 key-schedule engine. It accepts a 128-bit cipher key through a start handshake and generates the 44 expanded words, one word per clock, into an internal round-key store. The cipher datapath reads the 11 round keys by index. Status and per-round strobes let the round sequencer begin encrypting as soon as each round key is ready.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/key_schedule_ctrl_if.sv | 28 ++
 rtl/aes_subword.sv | 16 +
 rtl/key_schedule_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule states.
// Imported by the key schedule now and by the SubBytes stage later.
package aes_pkg;

  localparam int NWORDS     = 44;
  localparam int NROUNDKEYS = 11;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    FIN
  } ks_state_e;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Rcon is 1-based; out-of-table indices yield 0
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r - 4'd1];
    return v;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Start handshake, status strobes and round-key read port
// between the key schedule and the round sequencer.
interface key_schedule_ctrl_if;
  import aes_pkg::*;

  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_round,
    input  busy, done, keys_valid,
    input  rk_valid, rk_index, rd_key
  );

  modport slave (
    input  start, key_in, rd_round,
    output busy, done, keys_valid,
    output rk_valid, rk_index, rd_key
  );

endinterface

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  assign out_word = {
    sbox(in_word[31:24]),
    sbox(in_word[23:16]),
    sbox(in_word[15:8]),
    sbox(in_word[7:0])
  };

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key expansion, one word per clock.
// Optional KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
  input  logic zeroize,
`endif
  key_schedule_ctrl_if.slave bus
);

  if (NR != 10 || NK != 4) begin : g_bad_param
    $error("key_schedule_ctrl supports only NR=10, NK=4");
  end

  ks_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        keys_valid_q, keys_valid_d;
  logic        rk_valid_q, rk_valid_d;
  logic [3:0]  rk_index_q, rk_index_d;
  logic [31:0] w_q [NWORDS];
  logic [31:0] w_d [NWORDS];

  logic [5:0]  prev_idx;
  logic [31:0] prev;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;

  // cnt is 0 only outside GEN; clamp so the read stays in range
  assign prev_idx = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;
  assign prev     = w_q[prev_idx];
  assign rot      = {prev[23:0], prev[31:24]};

  aes_subword u_subword (
    .in_word  (rot),
    .out_word (sub)
  );

  always_comb begin
    temp = prev;
    if (cnt_q[1:0] == 2'd0) begin
      temp = sub ^ {rcon(cnt_q[5:2]), 24'h0};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keys_valid_d = keys_valid_q;
    rk_valid_d   = 1'b0;
    rk_index_d   = rk_index_q;
    w_d          = w_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_d[0]       = bus.key_in[127:96];
          w_d[1]       = bus.key_in[95:64];
          w_d[2]       = bus.key_in[63:32];
          w_d[3]       = bus.key_in[31:0];
          cnt_d        = 6'd4;
          keys_valid_d = 1'b0;
          rk_valid_d   = 1'b1;
          rk_index_d   = 4'd0;
          state_d      = GEN;
        end
      end
      GEN: begin
        w_d[cnt_q] = w_q[cnt_q - 6'd4] ^ temp;
        if (cnt_q[1:0] == 2'd3) begin
          rk_valid_d = 1'b1;
          rk_index_d = cnt_q[5:2];
        end
        if (cnt_q == 6'd43) begin
          state_d      = FIN;
          keys_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    // Wipe wins over everything, including a same-cycle start
    if (zeroize) begin
      state_d      = IDLE;
      cnt_d        = 6'd0;
      keys_valid_d = 1'b0;
      rk_valid_d   = 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        w_d[i] = 32'h0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      keys_valid_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_index_q   <= 4'd0;
      for (int i = 0; i < NWORDS; i++) begin
        w_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      keys_valid_q <= keys_valid_d;
      rk_valid_q   <= rk_valid_d;
      rk_index_q   <= rk_index_d;
      w_q          <= w_d;
    end
  end

  assign bus.busy       = (state_q == GEN);
  assign bus.done       = (state_q == FIN);
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_index   = rk_index_q;

  always_comb begin
    bus.rd_key = 128'h0;
    if (bus.rd_round < 4'(NROUNDKEYS)) begin
      bus.rd_key = {
        w_q[{bus.rd_round, 2'd0}],
        w_q[{bus.rd_round, 2'd1}],
        w_q[{bus.rd_round, 2'd2}],
        w_q[{bus.rd_round, 2'd3}]
      };
    end
  end

endmodule
